simple_fixed2_pipe: RTL and testbench
=====================================

Name: simple_fixed2_pipe

Overview:
- Parametrised successor to the SPU Simple Fixed 2 (shift/rotate) execution pipe.
- Executes the full halfword/word shift-left and rotate group in RR and RI7 forms: shlh, shl, roth, rot, shlhi, shli, rothi, roti.
- Result latency is set by a parameter.
- Adds a flush kill path, an illegal-opcode squash and a pipe-occupancy flag.
- Sits between the RF/FWD stage and the WB/register-table write port.

Parameters:
- LATENCY, 4, rising edges from the issue-sampling edge (inclusive) to the edge that updates the *_wb outputs; legal range 1..8.
- EN_ROTATE, 1, 1 = rotate opcodes are legal; 0 = rotate opcodes are treated as illegal.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- op  in  11 [0:10]  decoded opcode, truncated per format.
- format  in  3  0 = RR, 1 = RI7; all other values are illegal.
- rt_addr  in  7 [0:6]  destination register.
- ra  in  128 [0:127]  source A.
- rb  in  128 [0:127]  source B (RR forms only).
- imm  in  18 [0:17]  immediate; RI7 uses imm[11:17].
- reg_write  in  1  instruction writes the register table.
- flush  in  1  kill all in-flight instructions.
- rt_wb  out  128 [0:127]  result.
- rt_addr_wb  out  7 [0:6]  result destination.
- reg_write_wb  out  1  result is valid for writeback.
- busy  out  1  OR of the reg_write bits across all pipe stages.

Behaviour:
- Lanes:
  - Halfword lane i (0..7) = bits [16i +: 16].
  - Word lane j (0..3) = bits [32j +: 32].
  - Bit 0 is the MSB.
- Shift count:
  - RR forms: low bits of the matching rb lane.
  - RI7 forms: imm[11:17], applied to every lane.
- Opcodes and counts:
  - shlh 00001011111 / shlhi 00001111111: cnt = src & 0x1F; result = ra << cnt if cnt < 16, else 0.
  - shl 00001011011 / shli 00001111011: cnt = src & 0x3F; result = ra << cnt if cnt < 32, else 0.
  - roth 00001011100 / rothi 00001111100: rotate left by src & 0x0F.
  - rot 00001011000 / roti 00001111000: rotate left by src & 0x1F.
- nop (format 0, op 0): inserts a bubble with result 0, addr 0, reg_write 0.
- Illegal instruction (unlisted op, format > 1, or rotate with EN_ROTATE = 0): result 0, addr passed through, reg_write forced to 0. No other side effect.
- Pipeline:
  - LATENCY-deep shift register of {result, addr, reg_write}.
  - Issue sampled at edge E appears on the *_wb outputs after edge E+LATENCY-1.
  - Throughput is one instruction per cycle, with no stalls.
- Reset (reset = 0 at an edge):
  - All stages and all outputs go to 0 (rt_wb = 0, rt_addr_wb = 0, reg_write_wb = 0, busy = 0).
  - Reset mid-operation discards every in-flight instruction; the first post-reset issue follows normal latency.
- Flush (flush = 1 at an edge, reset deasserted):
  - Clears reg_write in every stage and in the instruction issued at that edge.
  - reg_write_wb is 0 after that edge.
  - Data and addr values may shift normally and are don't-care when reg_write = 0.
  - Flush together with an issue: the issued instruction is dropped.
  - Reset takes priority over flush.
- busy: registered; reflects the stage contents after each edge.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- shlh RR: ra hw0 = 16'h0001, rb hw0 = 16'h0004, hw1 ra = 16'hFFFF, rb = 16'h0013 -> after LATENCY edges rt_wb hw0 = 16'h0010, hw1 = 16'h0000, reg_write_wb = 1, rt_addr_wb = 7'd5 as issued.
- RI7 forms:
  - shli, ra word0 = 32'h0000_0001, imm[11:17] = 31 -> word0 = 32'h8000_0000.
  - shli with imm = 32 -> word0 = 0.
  - roti, ra word0 = 32'h1234_5678, imm = 7'h24 -> 32'h2345_6781.
  - rothi, ra hw = 16'h8001, imm = 7'h11 -> 16'h0003.
- Back-to-back issue of 4 distinct instructions, then nop -> outputs appear in order on consecutive cycles, followed by reg_write_wb = 0. busy = 1 while any stage is occupied, 0 afterwards.
- flush one cycle after issuing two instructions, with a third issued during the flush cycle -> none of the three ever produce reg_write_wb = 1. A fourth, issued the cycle after flush, appears normally.
- Illegal op 11'h7FF with reg_write = 1 -> reg_write_wb = 0, rt_wb = 0. Rebuild with EN_ROTATE = 0 and issue rot -> same squash.
- reset = 0 for one edge while 3 instructions are in flight -> all outputs and busy are 0 the following cycle. No squashed instruction reappears. Sweep LATENCY = 1, 4, 8.

Source files
------------

// File: rtl/simple_fixed2_pipe.sv
// Halfword/word shift-left and rotate execution pipe with LATENCY-deep result shift register.
// Every issue is accepted; flush kills in-flight writebacks, illegal opcodes are squashed at issue.
module simple_fixed2_pipe #(
  parameter int LATENCY   = 4,
  parameter bit EN_ROTATE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:10]  op,
  input  logic [2:0]   format,
  input  logic [0:6]   rt_addr,
  input  logic [0:127] ra,
  input  logic [0:127] rb,
  input  logic [0:17]  imm,
  input  logic         reg_write,
  input  logic         flush,
  output logic [0:127] rt_wb,
  output logic [0:6]   rt_addr_wb,
  output logic         reg_write_wb,
  output logic         busy
);

  localparam logic [10:0] OP_SHLH  = 11'b00001011111;
  localparam logic [10:0] OP_SHLHI = 11'b00001111111;
  localparam logic [10:0] OP_SHL   = 11'b00001011011;
  localparam logic [10:0] OP_SHLI  = 11'b00001111011;
  localparam logic [10:0] OP_ROTH  = 11'b00001011100;
  localparam logic [10:0] OP_ROTHI = 11'b00001111100;
  localparam logic [10:0] OP_ROT   = 11'b00001011000;
  localparam logic [10:0] OP_ROTI  = 11'b00001111000;

  typedef struct packed {
    logic [0:127] res;
    logic [0:6]   addr;
    logic         rw;
  } stage_t;

  // Shift counts at or beyond the lane width flush the lane to zero; rotates wrap.
  function automatic logic [15:0] hw_op(input logic [15:0] a, input logic [4:0] s, input logic rot);
    logic [31:0] t;
    t = {a, a} << s[3:0];
    if (rot) return t[31:16];
    return s[4] ? 16'h0000 : (a << s[3:0]);
  endfunction

  function automatic logic [31:0] wd_op(input logic [31:0] a, input logic [5:0] s, input logic rot);
    logic [63:0] t;
    t = {a, a} << s[4:0];
    if (rot) return t[63:32];
    return s[5] ? 32'h0 : (a << s[4:0]);
  endfunction

  logic         is_rr, is_ri, is_nop;
  logic         op_hw, op_rot, op_ok;
  logic [0:127] res_c;
  stage_t       issue_c;
  stage_t       stage_q [LATENCY];
  stage_t       stage_d [LATENCY];
  logic         busy_q, busy_d;
  logic         unused_bits;

  assign unused_bits = ^{imm[0:10], rb};

  always_comb begin
    is_rr  = (format == 3'd0);
    is_ri  = (format == 3'd1);
    is_nop = is_rr && (op == 11'd0);
    op_hw  = 1'b0;
    op_rot = 1'b0;
    op_ok  = 1'b0;
    case (op)
      OP_SHLH:  begin op_ok = is_rr; op_hw = 1'b1; end
      OP_SHLHI: begin op_ok = is_ri; op_hw = 1'b1; end
      OP_SHL:   op_ok = is_rr;
      OP_SHLI:  op_ok = is_ri;
      OP_ROTH:  begin op_ok = is_rr && EN_ROTATE; op_hw = 1'b1; op_rot = 1'b1; end
      OP_ROTHI: begin op_ok = is_ri && EN_ROTATE; op_hw = 1'b1; op_rot = 1'b1; end
      OP_ROT:   begin op_ok = is_rr && EN_ROTATE; op_rot = 1'b1; end
      OP_ROTI:  begin op_ok = is_ri && EN_ROTATE; op_rot = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    res_c = '0;
    if (op_hw) begin
      for (int i = 0; i < 8; i++)
        res_c[16*i +: 16] = hw_op(ra[16*i +: 16],
                                  is_ri ? imm[13:17] : rb[16*i+11 +: 5], op_rot);
    end else begin
      for (int j = 0; j < 4; j++)
        res_c[32*j +: 32] = wd_op(ra[32*j +: 32],
                                  is_ri ? imm[12:17] : rb[32*j+26 +: 6], op_rot);
    end
  end

  // A nop is a pure bubble; an illegal op keeps its address but never writes.
  always_comb begin
    issue_c = '0;
    if (!is_nop) begin
      issue_c.addr = rt_addr;
      if (op_ok) begin
        issue_c.res = res_c;
        issue_c.rw  = reg_write;
      end
    end
  end

  always_comb begin
    stage_d[0] = issue_c;
    for (int k = 1; k < LATENCY; k++) stage_d[k] = stage_q[k-1];
    busy_d = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      stage_d[k].rw = stage_d[k].rw & ~flush;
      busy_d        = busy_d | stage_d[k].rw;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= stage_d[k];
      busy_q <= busy_d;
    end
  end

  assign rt_wb        = stage_q[LATENCY-1].res;
  assign rt_addr_wb   = stage_q[LATENCY-1].addr;
  assign reg_write_wb = stage_q[LATENCY-1].rw;
  assign busy         = busy_q;

endmodule

// File: tb/tb_simple_fixed2_pipe.sv
// Directed bench for simple_fixed2_pipe: four instances (LATENCY 4/1/8, and 4 with rotates disabled)
// share one stimulus stream; each is checked at its own latency.
module tb_simple_fixed2_pipe;

  localparam logic [10:0] OP_SHLH  = 11'b00001011111;
  localparam logic [10:0] OP_SHLHI = 11'b00001111111;
  localparam logic [10:0] OP_SHL   = 11'b00001011011;
  localparam logic [10:0] OP_SHLI  = 11'b00001111011;
  localparam logic [10:0] OP_ROTH  = 11'b00001011100;
  localparam logic [10:0] OP_ROTHI = 11'b00001111100;
  localparam logic [10:0] OP_ROT   = 11'b00001011000;
  localparam logic [10:0] OP_ROTI  = 11'b00001111000;

  logic         clk = 1'b0;
  logic         reset;
  logic [10:0]  op;
  logic [2:0]   format;
  logic [6:0]   rt_addr;
  logic [127:0] ra, rb;
  logic [17:0]  imm;
  logic         reg_write, flush;

  logic [127:0] rt_wb_w [4];
  logic [6:0]   addr_w  [4];
  logic         rw_w    [4];
  logic         busy_w  [4];

  int n_vec = 0;
  int n_err = 0;

  logic [10:0]  s_op   [4];
  logic [2:0]   s_fmt  [4];
  logic [127:0] s_ra   [4];
  logic [127:0] s_rb   [4];
  logic [17:0]  s_imm  [4];
  logic [127:0] s_exp  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    simple_fixed2_pipe #(
      .LATENCY  ((g == 1) ? 1 : (g == 2) ? 8 : 4),
      .EN_ROTATE(g != 3)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .format      (format),
      .rt_addr     (rt_addr),
      .ra          (ra),
      .rb          (rb),
      .imm         (imm),
      .reg_write   (reg_write),
      .flush       (flush),
      .rt_wb       (rt_wb_w[g]),
      .rt_addr_wb  (addr_w[g]),
      .reg_write_wb(rw_w[g]),
      .busy        (busy_w[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 8 : 4;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [10:0] o, input logic [2:0] f, input logic [6:0] a,
                       input logic [127:0] xa, input logic [127:0] xb, input logic [17:0] im,
                       input logic w);
    op = o; format = f; rt_addr = a; ra = xa; rb = xb; imm = im; reg_write = w;
  endtask

  task automatic drive_nop();
    drive(11'd0, 3'd0, 7'd0, '0, '0, '0, 1'b0);
  endtask

  // Single issue, then bubbles; each instance checked on the cycle its result lands.
  task automatic run_one(input string tag, input logic [10:0] o, input logic [2:0] f,
                         input logic [6:0] a, input logic [127:0] xa, input logic [127:0] xb,
                         input logic [17:0] im, input logic w, input logic [127:0] er,
                         input logic [6:0] ea, input logic ew, input logic rotop);
    logic [127:0] r;
    logic         e;
    drive(o, f, a, xa, xb, im, w);
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 1) drive_nop();
      for (int k = 0; k < 4; k++) begin
        if (lat_of(k) == n) begin
          r = (k == 3 && rotop) ? '0 : er;
          e = (k == 3 && rotop) ? 1'b0 : ew;
          chk($sformatf("%s/u%0d/res", tag, k), rt_wb_w[k], r);
          chk($sformatf("%s/u%0d/addr", tag, k), 128'(addr_w[k]), 128'(ea));
          chk($sformatf("%s/u%0d/rw", tag, k), 128'(rw_w[k]), 128'(e));
        end
      end
    end
  endtask

  // Four back-to-back issues then bubbles; fstep (0 = none) is the step carrying flush.
  task automatic run_stream(input string tag, input int fstep);
    int  s, lat;
    logic live, bexp;
    for (int n = 1; n <= 12; n++) begin
      if (n <= 4) drive(s_op[n-1], s_fmt[n-1], 7'(n), s_ra[n-1], s_rb[n-1], s_imm[n-1], 1'b1);
      else drive_nop();
      flush = (n == fstep);
      step();
      for (int k = 0; k < 4; k++) begin
        lat  = lat_of(k);
        s    = n - lat + 1;
        live = (s >= 1) && (s <= 4) && !((fstep >= s) && (fstep <= n));
        chk($sformatf("%s/n%0d/u%0d/rw", tag, n, k), 128'(rw_w[k]), 128'(live));
        if (live) begin
          chk($sformatf("%s/n%0d/u%0d/res", tag, n, k), rt_wb_w[k], s_exp[s-1]);
          chk($sformatf("%s/n%0d/u%0d/addr", tag, n, k), 128'(addr_w[k]), 128'(s));
        end
        bexp = 1'b0;
        for (int s2 = 1; s2 <= 4; s2++)
          if ((s2 <= n) && (n <= s2 + lat - 1) && !((fstep >= s2) && (fstep <= n))) bexp = 1'b1;
        chk($sformatf("%s/n%0d/u%0d/busy", tag, n, k), 128'(busy_w[k]), 128'(bexp));
      end
    end
    flush = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s/u%0d/res", tag, k), rt_wb_w[k], '0);
      chk($sformatf("%s/u%0d/addr", tag, k), 128'(addr_w[k]), '0);
      chk($sformatf("%s/u%0d/rw", tag, k), 128'(rw_w[k]), '0);
      chk($sformatf("%s/u%0d/busy", tag, k), 128'(busy_w[k]), '0);
    end
  endtask

  initial begin
    s_op[0] = OP_SHLH;  s_fmt[0] = 3'd0; s_imm[0] = '0;
    s_ra[0] = {16'h0003, 112'h0}; s_rb[0] = {16'h0002, 112'h0}; s_exp[0] = {16'h000C, 112'h0};
    s_op[1] = OP_SHL;   s_fmt[1] = 3'd0; s_imm[1] = '0;
    s_ra[1] = 128'h1; s_rb[1] = 128'h1F; s_exp[1] = 128'h8000_0000;
    s_op[2] = OP_SHLHI; s_fmt[2] = 3'd1; s_imm[2] = 18'd4;
    s_ra[2] = {8{16'h0101}}; s_rb[2] = '0; s_exp[2] = {8{16'h1010}};
    s_op[3] = OP_SHLI;  s_fmt[3] = 3'd1; s_imm[3] = 18'd8;
    s_ra[3] = {4{32'h00AB_CDEF}}; s_rb[3] = '0; s_exp[3] = {4{32'hABCD_EF00}};

    reset = 1'b0;
    flush = 1'b0;
    drive_nop();
    step();
    step();
    chk_idle("reset");
    reset = 1'b1;

    run_one("shlh_rr", OP_SHLH, 3'd0, 7'd5,
            {16'h0001, 16'hFFFF, 16'h8001, 16'h00FF, 64'h0},
            {16'h0004, 16'h0013, 16'h0010, 16'h0028, 64'h0}, '0, 1'b1,
            {16'h0010, 16'h0000, 16'h0000, 16'hFF00, 64'h0}, 7'd5, 1'b1, 1'b0);
    run_one("shli31", OP_SHLI, 3'd1, 7'd6, {32'h1, 96'h0}, '0, 18'd31, 1'b1,
            {32'h8000_0000, 96'h0}, 7'd6, 1'b1, 1'b0);
    run_one("shli32", OP_SHLI, 3'd1, 7'd7, {32'h1, 96'h0}, '0, 18'd32, 1'b1,
            '0, 7'd7, 1'b1, 1'b0);
    run_one("roti", OP_ROTI, 3'd1, 7'd8, {32'h1234_5678, 96'h0}, '0, 18'h24, 1'b1,
            {32'h2345_6781, 96'h0}, 7'd8, 1'b1, 1'b1);
    run_one("rothi", OP_ROTHI, 3'd1, 7'd9, {16'h8001, 112'h0}, '0, 18'h11, 1'b1,
            {16'h0003, 112'h0}, 7'd9, 1'b1, 1'b1);
    run_one("rot_rr", OP_ROT, 3'd0, 7'd10, {32'h8000_0001, 32'hF000_000F, 64'h0},
            {32'h21, 32'h3F, 64'h0}, '0, 1'b1,
            {32'h0000_0003, 32'hF800_0007, 64'h0}, 7'd10, 1'b1, 1'b1);
    run_one("shl_rr", OP_SHL, 3'd0, 7'd11, {32'h0000_FFFF, 32'h1, 32'h1, 32'h0},
            {32'h10, 32'h40, 32'h20, 32'h0}, '0, 1'b1,
            {32'hFFFF_0000, 32'h1, 32'h0, 32'h0}, 7'd11, 1'b1, 1'b0);
    run_one("roth_rr", OP_ROTH, 3'd0, 7'd12, {16'h1234, 16'hABCD, 96'h0},
            {16'h0004, 16'h0010, 96'h0}, '0, 1'b1,
            {16'h2341, 16'hABCD, 96'h0}, 7'd12, 1'b1, 1'b1);
    run_one("illegal", 11'h7FF, 3'd0, 7'd13, 128'h1, 128'h1, '0, 1'b1, '0, 7'd13, 1'b0, 1'b0);
    run_one("badfmt", OP_SHL, 3'd2, 7'd14, 128'h1, 128'h1, '0, 1'b1, '0, 7'd14, 1'b0, 1'b0);
    run_one("nop", 11'd0, 3'd0, 7'd15, 128'h1, 128'h1, '0, 1'b1, '0, 7'd0, 1'b0, 1'b0);

    run_stream("b2b", 0);
    run_stream("flush", 3);

    for (int n = 0; n < 3; n++) begin
      drive(s_op[n], s_fmt[n], 7'(n + 1), s_ra[n], s_rb[n], s_imm[n], 1'b1);
      step();
    end
    drive_nop();
    reset = 1'b0;
    step();
    chk_idle("midreset");
    reset = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("postreset/n%0d/u%0d/rw", n, k), 128'(rw_w[k]), '0);
        chk($sformatf("postreset/n%0d/u%0d/busy", n, k), 128'(busy_w[k]), '0);
      end
    end
    run_one("after_reset", s_op[3], s_fmt[3], 7'd21, s_ra[3], s_rb[3], s_imm[3], 1'b1,
            s_exp[3], 7'd21, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
